// File: rtl/mips_pkg.sv
// Opcode/func codes, PC select codes and the enums shared by the
// multi-cycle MIPS controller and its decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam logic [1:0] PC_SEQ     = 2'd0;
    localparam logic [1:0] PC_BRANCH  = 2'd1;
    localparam logic [1:0] PC_JUMP    = 2'd2;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_SYSCALL, C_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake with the shared single-port memory: request, write qualifier,
// address select and the completion strobe coming back.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/instr_class_decode.sv
// Combinational opcode/func classifier; anything not listed is illegal.
module instr_class_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output iclass_t    iclass
);

    // Two-level lookup: func only matters for the R-type opcode.
    always_comb begin
        iclass = C_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: iclass = C_RTYPE;
                    FN_SYSCALL:                            iclass = C_SYSCALL;
                    default:                               iclass = C_ILLEGAL;
                endcase
            end
            OP_ADDI: iclass = C_ADDI;
            OP_LW:   iclass = C_LW;
            OP_SW:   iclass = C_SW;
            OP_BEQ:  iclass = C_BEQ;
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait
// states, SYSCALL halt and illegal-instruction / memory-timeout error.
// Selects and mem_req are registered from the next state; the strobes that
// depend on mem_ready or zero in the same cycle (ir_we, pc_we, instr_done)
// are decoded from the registered state and qualified by those inputs.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic              zero,
    multicycle_ctrl_if.master mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              reg_we,
    output logic              alu_src,
    output logic              reg_dest,
    output logic              mem_or_reg,
    output logic              link,
    output logic              branch,
    output logic              instr_done,
    output logic              halted,
    output logic              err
);

    // Timeout fires on the waiting cycle that brings the count to MEM_WAIT_MAX.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state, nxt;
    iclass_t    cls, dec_cls, cls_nxt;
    logic [7:0] wait_cnt;
    logic       req_q, we_q, iord_q;
    logic       accept, tmo, nxt_in_ex;

    instr_class_decode u_dec (
        .opcode (opcode),
        .func   (func),
        .iclass (dec_cls)
    );

    // mem_ready only counts while a request is actually outstanding.
    assign accept    = req_q && mem.mem_ready;
    assign tmo       = req_q && !mem.mem_ready && (wait_cnt == WAIT_LAST);
    assign cls_nxt   = (state == DECODE) ? dec_cls : cls;
    assign nxt_in_ex = (nxt == EXEC) || (nxt == MEM) || (nxt == WB);

    assign mem.mem_req = req_q;
    assign mem.mem_we  = we_q;
    assign mem.iord    = iord_q;

    assign ir_we      = (state == FETCH) && accept;
    assign pc_we      = ir_we ||
                        ((state == EXEC) &&
                         ((cls == C_J) || (cls == C_JAL) || ((cls == C_BEQ) && zero)));
    assign instr_done = ((state == EXEC) && ((cls == C_BEQ) || (cls == C_J))) ||
                        ((state == MEM) && accept && (cls == C_SW)) ||
                        (state == WB);

    // Next-state selection; HALT and ERR hold until reset.
    always_comb begin
        nxt = state;
        case (state)
            FETCH: begin
                if (tmo)         nxt = ERR;
                else if (accept) nxt = DECODE;
            end
            DECODE: begin
                case (dec_cls)
                    C_SYSCALL: nxt = HALT;
                    C_ILLEGAL: nxt = ERR;
                    default:   nxt = EXEC;
                endcase
            end
            EXEC: begin
                case (cls)
                    C_BEQ, C_J: nxt = FETCH;
                    C_LW, C_SW: nxt = MEM;
                    default:    nxt = WB;
                endcase
            end
            MEM: begin
                if (tmo)         nxt = ERR;
                else if (accept) nxt = (cls == C_SW) ? FETCH : WB;
            end
            WB:      nxt = FETCH;
            default: nxt = state;
        endcase
    end

    // State, class, wait counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= FETCH;
            cls        <= C_ILLEGAL;
            wait_cnt   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            iord_q     <= 1'b0;
            pc_src     <= PC_SEQ;
            reg_we     <= 1'b0;
            alu_src    <= 1'b0;
            reg_dest   <= 1'b0;
            mem_or_reg <= 1'b0;
            link       <= 1'b0;
            branch     <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state    <= nxt;
            cls      <= cls_nxt;
            wait_cnt <= (req_q && !mem.mem_ready && (nxt == state)) ? wait_cnt + 8'd1 : '0;
            // Drop the request for one cycle after every completion, so a
            // fetch that follows a store starts with a fresh request.
            req_q    <= ((nxt == FETCH) || (nxt == MEM)) && !accept;
            iord_q   <= (nxt == MEM);
            we_q     <= (nxt == MEM) && (cls_nxt == C_SW);
            branch   <= (nxt == EXEC) && (cls_nxt == C_BEQ);
            if ((nxt == EXEC) && (cls_nxt == C_BEQ))
                pc_src <= PC_BRANCH;
            else if ((nxt == EXEC) && ((cls_nxt == C_J) || (cls_nxt == C_JAL)))
                pc_src <= PC_JUMP;
            else
                pc_src <= PC_SEQ;
            reg_we     <= (nxt == WB);
            mem_or_reg <= (nxt == WB) && (cls_nxt == C_LW);
            link       <= (nxt == WB) && (cls_nxt == C_JAL);
            alu_src    <= nxt_in_ex &&
                          ((cls_nxt == C_ADDI) || (cls_nxt == C_LW) || (cls_nxt == C_SW));
            reg_dest   <= nxt_in_ex && (cls_nxt == C_RTYPE);
            halted     <= (nxt == HALT);
            err        <= (nxt == ERR);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each queued instruction pushes its expected retirement
// record; a negedge monitor accumulates per-instruction observations and
// compares on instr_done / halted / err.
module tb_multicycle_ctrl;

    localparam int W = 4;   // MEM_WAIT_MAX used for the DUT

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       ir_we, pc_we, reg_we, alu_src, reg_dest, mem_or_reg, link, branch;
    logic       instr_done, halted, err;
    logic [1:0] pc_src;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.MEM_WAIT_MAX(W)) dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func), .zero(zero),
        .mem(mif), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .alu_src(alu_src), .reg_dest(reg_dest), .mem_or_reg(mem_or_reg), .link(link),
        .branch(branch), .instr_done(instr_done), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         z;
        int         fw;
        int         mw;
    } instr_t;

    // kind: 0 retire, 1 halt, 2 error
    typedef struct {
        int kind, cyc, n_irw, n_rw, n_pcw, n_br, n_dreq, n_we, pcsrc;
        bit mor, rd, lnk, alu, chk_alu;
    } rsp_t;

    instr_t prog_q[$];
    rsp_t   exp_q[$];
    int     vecs = 0;
    int     bad = 0;
    int     last_kind = 0;

    task automatic chk(input string name, input int act, input int expv);
        vecs++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference: cycles counted from the first cycle of the fetch request to
    // the cycle the instruction retires (or halted/err first shows).
    function automatic rsp_t model(input instr_t i);
        rsp_t r;
        int   k;
        r.kind = 0; r.cyc = 0; r.n_irw = 0; r.n_rw = 0; r.n_pcw = 0; r.n_br = 0;
        r.n_dreq = 0; r.n_we = 0; r.pcsrc = 0; r.mor = 0; r.rd = 0; r.lnk = 0;
        r.alu = 0; r.chk_alu = 0;
        if (i.op == 6'h00) begin
            case (i.fn)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: k = 0;
                6'h0c:                             k = 7;
                default:                           k = 8;
            endcase
        end else begin
            case (i.op)
                6'h08:   k = 1;
                6'h23:   k = 2;
                6'h2b:   k = 3;
                6'h04:   k = 4;
                6'h02:   k = 5;
                6'h03:   k = 6;
                default: k = 8;
            endcase
        end
        if (i.fw >= W) begin
            r.kind = 2; r.cyc = W + 1;
            return r;
        end
        r.n_irw = 1;
        case (k)
            7: begin r.kind = 1; r.cyc = i.fw + 3; end
            8: begin r.kind = 2; r.cyc = i.fw + 3; end
            4: begin r.cyc = i.fw + 3; r.n_br = 1; r.n_pcw = i.z ? 1 : 0; r.pcsrc = 1;
                     r.chk_alu = 1; r.alu = 0; end
            5: begin r.cyc = i.fw + 3; r.n_pcw = 1; r.pcsrc = 2; end
            6: begin r.cyc = i.fw + 4; r.n_pcw = 1; r.pcsrc = 2; r.n_rw = 1; r.lnk = 1; end
            0: begin r.cyc = i.fw + 4; r.n_rw = 1; r.rd = 1; r.chk_alu = 1; r.alu = 0; end
            1: begin r.cyc = i.fw + 4; r.n_rw = 1; r.chk_alu = 1; r.alu = 1; end
            default: begin   // LW / SW
                r.chk_alu = 1; r.alu = 1;
                if (i.mw >= W) begin
                    r.kind = 2; r.cyc = i.fw + W + 4; r.n_dreq = W;
                    r.n_we = (k == 3) ? W : 0;
                end else begin
                    r.n_dreq = i.mw + 1;
                    r.n_we   = (k == 3) ? i.mw + 1 : 0;
                    r.cyc    = i.fw + i.mw + ((k == 2) ? 5 : 4);
                    if (k == 2) begin r.n_rw = 1; r.mor = 1; end
                end
            end
        endcase
        return r;
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input int fw, input int mw);
        instr_t i;
        rsp_t   r;
        i.op = op; i.fn = fn; i.z = z; i.fw = fw; i.mw = mw;
        r = model(i);
        prog_q.push_back(i);
        exp_q.push_back(r);
        last_kind = r.kind;
    endtask

    // Memory responder: completes each request after its planned wait count,
    // and toggles mem_ready randomly while nothing is requested.
    initial begin
        instr_t cur;
        int     rc;
        rc = 0;
        cur.op = '0; cur.fn = '0; cur.z = 0; cur.fw = 1000; cur.mw = 1000;
        mif.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_b || !mif.mem_req) begin
                rc = 0;
                mif.mem_ready = 1'($urandom_range(0, 1));
            end else begin
                if (rc == 0 && !mif.iord) begin
                    if (prog_q.size() > 0) cur = prog_q.pop_front();
                    else begin cur.fw = 1000; cur.mw = 1000; end
                    opcode = cur.op; func = cur.fn; zero = cur.z;
                end
                mif.mem_ready = (rc == (mif.iord ? cur.mw : cur.fw));
                rc++;
            end
        end
    end

    // Monitor: accumulate per-instruction observations, compare on retire.
    bit active = 0;
    int o_cyc, o_irw, o_rw, o_pcw, o_br, o_dreq, o_we, o_pcsrc, o_fbad;
    bit o_mor, o_rd, o_lnk, o_alu;

    always @(negedge clk) begin
        if (!rst_b) begin
            active = 0;
        end else begin
            chk("halt_err_exclusive", int'(halted && err), 0);
            if (!active && mif.mem_req && !mif.iord) begin
                active = 1;
                o_cyc = 0; o_irw = 0; o_rw = 0; o_pcw = 0; o_br = 0; o_dreq = 0;
                o_we = 0; o_pcsrc = 0; o_fbad = 0; o_mor = 0; o_rd = 0; o_lnk = 0; o_alu = 0;
            end
            if (active) begin
                o_cyc++;
                if (ir_we) begin
                    o_irw++;
                    if (!pc_we || pc_src != 2'd0) o_fbad++;
                end
                if (pc_we && !ir_we) begin o_pcw++; o_pcsrc = pc_src; end
                if (reg_we) begin o_rw++; o_mor = mem_or_reg; o_rd = reg_dest; o_lnk = link; end
                if (branch) o_br++;
                if (mif.mem_req && mif.iord) begin o_dreq++; if (mif.mem_we) o_we++; end
                if (reg_we || branch || (mif.mem_req && mif.iord)) o_alu = alu_src;
                if (instr_done || halted || err) begin
                    active = 0;
                    if (exp_q.size() == 0) begin
                        vecs++; bad++;
                        $display("FAIL unexpected_retire: got retire/halt/err, expected none");
                    end else begin
                        rsp_t e;
                        e = exp_q.pop_front();
                        chk("kind", halted ? 1 : (err ? 2 : 0), e.kind);
                        chk("latency", o_cyc, e.cyc);
                        chk("ir_we_count", o_irw, e.n_irw);
                        chk("fetch_pc_update", o_fbad, 0);
                        chk("reg_we_count", o_rw, e.n_rw);
                        chk("pc_we_exec_count", o_pcw, e.n_pcw);
                        chk("branch_count", o_br, e.n_br);
                        chk("data_req_cycles", o_dreq, e.n_dreq);
                        chk("mem_we_cycles", o_we, e.n_we);
                        if (e.n_rw > 0) begin
                            chk("mem_or_reg", int'(o_mor), int'(e.mor));
                            chk("reg_dest", int'(o_rd), int'(e.rd));
                            chk("link", int'(o_lnk), int'(e.lnk));
                        end
                        if (e.n_pcw > 0) chk("pc_src", o_pcsrc, e.pcsrc);
                        if (e.chk_alu)   chk("alu_src", int'(o_alu), int'(e.alu));
                    end
                end
            end
        end
    end

    function automatic int all_outs();
        return int'({mif.mem_req, mif.mem_we, mif.iord, ir_we, pc_we, pc_src, reg_we,
                     alu_src, reg_dest, mem_or_reg, link, branch, instr_done, halted, err});
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1 chk("reset_outputs", all_outs(), 0);
        prog_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_b = 1'b1;
    endtask

    // Wait for the scoreboard to drain, then confirm the terminal state is quiet.
    task automatic finish_prog();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 600) begin @(posedge clk); n++; end
        chk("drain_bound", exp_q.size(), 0);
        exp_q.delete();
        repeat (5) begin
            @(negedge clk);
            chk("terminal_quiet", int'({mif.mem_req, ir_we, pc_we, reg_we, instr_done}), 0);
        end
        chk("terminal_flags", int'({halted, err}), (last_kind == 1) ? 2 : 1);
    endtask

    task automatic pick_legal(input int s, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom_range(0, 63));
        case (s)
            0: begin op = 6'h00; fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h22; end
            2: begin op = 6'h00; fn = 6'h24; end
            3: begin op = 6'h00; fn = 6'h25; end
            4: begin op = 6'h00; fn = 6'h2a; end
            5: op = 6'h08;
            6: op = 6'h23;
            7: op = 6'h2b;
            8: op = 6'h04;
            9: op = 6'h02;
            default: op = 6'h03;
        endcase
    endtask

    initial begin
        int         n;
        logic [5:0] op, fn;
        do_reset();
        // ADD with immediate fetch, then SYSCALL
        add(6'h00, 6'h20, 0, 0, 0);
        add(6'h00, 6'h0c, 0, 0, 0);
        finish_prog();

        do_reset();
        add(6'h23, 6'h00, 0, 0, 3);   // LW, 3 wait cycles in MEM
        add(6'h2b, 6'h00, 0, 1, 2);   // SW
        add(6'h04, 6'h00, 1, 0, 0);   // BEQ taken
        add(6'h04, 6'h00, 0, 0, 0);   // BEQ not taken
        add(6'h02, 6'h00, 0, 2, 0);   // J
        add(6'h03, 6'h00, 0, 0, 0);   // JAL
        add(6'h08, 6'h00, 0, 3, 0);   // ADDI, longest legal fetch wait
        add(6'h00, 6'h22, 0, 0, 0);   // SUB
        add(6'h00, 6'h24, 1, 1, 0);   // AND
        add(6'h00, 6'h25, 0, 0, 0);   // OR
        add(6'h00, 6'h2a, 0, 0, 0);   // SLT
        add(6'h2b, 6'h00, 0, 0, 0);   // SW back-to-back with next fetch
        add(6'h00, 6'h0c, 0, 0, 0);
        finish_prog();

        do_reset(); add(6'h3f, 6'h00, 0, 0, 0); finish_prog();        // illegal opcode
        do_reset(); add(6'h00, 6'h21, 0, 1, 0); finish_prog();        // illegal func
        do_reset(); add(6'h00, 6'h20, 0, 30, 0); finish_prog();       // fetch timeout
        do_reset(); add(6'h00, 6'h20, 0, 3, 0); add(6'h23, 6'h00, 0, 0, W); finish_prog();
        do_reset(); add(6'h2b, 6'h00, 0, 0, W + 5); finish_prog();    // SW timeout

        for (int t = 0; t < 12; t++) begin
            do_reset();
            n = $urandom_range(4, 10);
            for (int j = 0; j < n; j++) begin
                pick_legal($urandom_range(0, 10), op, fn);
                add(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            case ($urandom_range(0, 3))
                0:       add(6'h00, 6'h0c, 0, $urandom_range(0, 3), 0);
                1:       add(6'h3f, 6'h00, 0, $urandom_range(0, 3), 0);
                2:       add(6'h00, 6'h01, 0, $urandom_range(0, 3), 0);
                default: add(6'h00, 6'h20, 0, $urandom_range(W, W + 3), 0);
            endcase
            finish_prog();
        end

        // Reset asserted mid-cycle while a load waits in MEM
        do_reset();
        add(6'h23, 6'h00, 0, 0, 20);
        n = 0;
        while (!(mif.mem_req && mif.iord) && n < 50) begin @(negedge clk); n++; end
        chk("mem_phase_reached", int'(mif.mem_req && mif.iord), 1);
        @(posedge clk);
        #3 rst_b = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 0);
        prog_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_b = 1'b1;
        add(6'h00, 6'h20, 0, 0, 0);
        add(6'h00, 6'h0c, 0, 0, 0);
        n = 0;
        while (!mif.mem_req && n < 5) begin @(negedge clk); n++; end
        chk("post_reset_fetch", int'({mif.mem_req, mif.iord}), 2);
        finish_prog();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
